// File: rtl/esm_ad9361_tune_sequencer_if.sv
// Tune request / AD9361 control bundle between the dwell controller and the tune sequencer.
interface esm_ad9361_tune_sequencer_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   Req_valid;
  logic [2:0]             Req_profile;
  logic                   Req_ready;
  logic [3:0]             Ad9361_control;
  logic [7:0]             Ad9361_status;
  logic                   Tune_done;
  logic                   Tune_timeout;
  logic [COUNT_WIDTH-1:0] Settle_cycles;
  logic                   Busy;

  modport master (
    output Req_valid, Req_profile, Ad9361_status,
    input  Req_ready, Ad9361_control, Tune_done, Tune_timeout, Settle_cycles, Busy
  );

  modport slave (
    input  Req_valid, Req_profile, Ad9361_status,
    output Req_ready, Ad9361_control, Tune_done, Tune_timeout, Settle_cycles, Busy
  );
endinterface

// File: rtl/esm_ad9361_tune_sequencer.sv
// AD9361 fast-lock retune sequencer: apply profile, blank stale status, wait for lock or timeout,
// report settle time. Re-requesting the already-locked profile completes without touching control.
module esm_ad9361_tune_sequencer #(
  parameter int unsigned BLANK_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter logic [7:0]  LOCK_MASK      = 8'hFF
) (
  input logic                          Clk,
  input logic                          Rst,
  esm_ad9361_tune_sequencer_if.slave   tune_if
);

  localparam logic [COUNT_WIDTH-1:0] BLANK_LAST = COUNT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] WAIT_LAST  = COUNT_WIDTH'(BLANK_CYCLES + TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TOTAL      = COUNT_WIDTH'(BLANK_CYCLES + TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, APPLY, BLANK, WAIT_LOCK, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [COUNT_WIDTH-1:0] counter_inc;
  logic [COUNT_WIDTH-1:0] settle_res;
  logic [COUNT_WIDTH-1:0] settle_q;
  logic                   timeout_res;
  logic                   timeout_q;
  logic [2:0]             profile_q;
  logic [2:0]             current_profile;
  logic                   profile_valid;
  logic [3:0]             control_q;
  logic                   done_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   locked;

  always_comb begin
    locked      = (tune_if.Ad9361_status & LOCK_MASK) == LOCK_MASK;
    counter_inc = (counter == '1) ? counter : counter + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      counter         <= '0;
      settle_res      <= '0;
      settle_q        <= '0;
      timeout_res     <= 1'b0;
      timeout_q       <= 1'b0;
      profile_q       <= '0;
      current_profile <= '0;
      profile_valid   <= 1'b0;
      control_q       <= '0;
      done_q          <= 1'b0;
      ready_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          // ready_q is low in the first cycle after reset, so no accept can happen there
          if (tune_if.Req_valid && ready_q) begin
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            profile_q <= tune_if.Req_profile;
            if (profile_valid && (tune_if.Req_profile == current_profile) && locked) begin
              settle_res  <= '0;
              timeout_res <= 1'b0;
              state       <= DONE;
            end else begin
              state <= APPLY;
            end
          end
        end
        APPLY: begin
          control_q <= {1'b1, profile_q};
          counter   <= '0;
          state     <= BLANK;
        end
        BLANK: begin
          counter <= counter_inc;
          if (counter == BLANK_LAST) state <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          counter <= counter_inc;
          // lock is tested first so a lock on the final timeout cycle still counts as success
          if (locked) begin
            settle_res  <= counter;
            timeout_res <= 1'b0;
            state       <= DONE;
          end else if (counter == WAIT_LAST) begin
            settle_res  <= TOTAL;
            timeout_res <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done_q          <= 1'b1;
          timeout_q       <= timeout_res;
          settle_q        <= settle_res;
          current_profile <= profile_q;
          profile_valid   <= 1'b1;
          ready_q         <= 1'b1;
          busy_q          <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tune_if.Req_ready      = ready_q;
  assign tune_if.Ad9361_control = control_q;
  assign tune_if.Tune_done      = done_q;
  assign tune_if.Tune_timeout   = timeout_q;
  assign tune_if.Settle_cycles  = settle_q;
  assign tune_if.Busy           = busy_q;

endmodule
